// File: rtl/posit_divider.sv
// Sequential posit<N,ES> divider, q = a / b.
// Operands are decoded to sign/scale/fraction, the significands go through a
// restoring divider (one quotient bit per cycle), and the result is re-encoded
// with round-to-nearest-even. Exactly one operation is in flight at a time.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Once out_valid is raised, q (and flags) are held stable until the
// edge where out_ready is also high. in_ready is high only while idle.
//
// Optional feature: define POSIT_DIV_FLAGS_EN to add the 4-bit flags output
// {nar, ovf_sat, unf_sat, inexact}. Without it there is no flag logic at all.
module posit_divider #(
  parameter int N  = 32,
  parameter int ES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q
`ifdef POSIT_DIV_FLAGS_EN
  ,
  output logic [3:0]   flags
`endif
);

  localparam int FRAC_W = N - 3 - ES;      // widest fraction field
  localparam int QW     = FRAC_W + 3;      // quotient bits, incl. integer bit
  localparam int SW     = 11;              // signed scale width
  localparam int VW     = 2 * N;           // encoder staging width
  localparam int CW     = $clog2(QW);

  localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS = {{(N-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] MAXSC = SW'((N - 2) << ES);
  localparam logic signed [SW-1:0] MINSC = -MAXSC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_DIVIDE,
    S_ENCODE,
    S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [N-1:0]           r_a, r_b, r_q;
  logic                   r_sign, r_special, r_in_ready, r_out_valid;
  logic signed [SW-1:0]   r_scale;
  logic [QW-2:0]          r_rem;    // partial remainder, always < 2 * divisor
  logic [FRAC_W:0]        r_div;    // {1, fb}
  logic [QW-1:0]          r_quo;
  logic [CW-1:0]          r_cnt;
`ifdef POSIT_DIV_FLAGS_EN
  logic [3:0]             r_flags;
`endif

  // Magnitude, regime run, exponent and fraction of one operand.
  // Returns {scale, fraction left-aligned to FRAC_W}.
  function automatic logic [SW+FRAC_W-1:0] decode_op(input logic [N-1:0] x);
    logic [N-2:0]         body;
    logic [N-2:0]         shifted;
    logic                 first;
    logic                 run_on;
    int                   run;
    logic signed [SW-1:0] k;
    logic signed [SW-1:0] e_ext;
    logic signed [SW-1:0] sc;
    body   = x[N-1] ? (~x[N-2:0] + 1'b1) : x[N-2:0];
    first  = body[N-2];
    run    = 0;
    run_on = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      if (run_on && (body[i] == first)) run++;
      else run_on = 1'b0;
    end
    // Drop regime and terminator; missing exponent/fraction bits shift in as 0.
    shifted = body << (run + 1);
    k       = first ? SW'(run - 1) : -SW'(run);
    e_ext   = SW'(shifted[N-2 -: ES]);
    sc      = (k <<< ES) + e_ext;
    return {sc, shifted[N-2-ES -: FRAC_W]};
  endfunction

  logic [SW+FRAC_W-1:0] w_da, w_db;
  logic signed [SW-1:0] w_sa, w_sb;
  logic                 w_a_nar, w_b_nar, w_a_zero, w_b_zero, w_special;

  assign w_da      = decode_op(r_a);
  assign w_db      = decode_op(r_b);
  assign w_sa      = w_da[SW+FRAC_W-1 -: SW];
  assign w_sb      = w_db[SW+FRAC_W-1 -: SW];
  assign w_a_nar   = (r_a == NAR);
  assign w_b_nar   = (r_b == NAR);
  assign w_a_zero  = (r_a == '0);
  assign w_b_zero  = (r_b == '0);
  assign w_special = w_a_nar | w_b_nar | w_a_zero | w_b_zero;

  // One restoring-division step.
  logic          w_ge;
  logic [QW-2:0] w_sub, w_rem_sel;
  assign w_ge      = (r_rem >= {1'b0, r_div});
  assign w_sub     = r_rem - {1'b0, r_div};
  assign w_rem_sel = w_ge ? w_sub : r_rem;

  // Encoder: normalise, build {regime, exponent, fraction}, round, clamp.
  logic [QW-2:0]        w_frac;
  logic signed [SW-1:0] w_esc, w_k;
  logic [SW-1:0]        w_len;
  logic [ES-1:0]        w_e;
  logic [N-2:0]         w_tail, w_body;
  logic [VW-1:0]        w_mask, w_v;
  logic                 w_sticky, w_guard, w_rest, w_round;
  logic                 w_sat_hi, w_sat_lo, w_clamp_hi, w_clamp_lo;
  logic [N-1:0]         w_sum, w_mag, w_res;

  assign w_frac   = r_quo[QW-1] ? r_quo[QW-2:0] : {r_quo[QW-3:0], 1'b0};
  assign w_esc    = r_quo[QW-1] ? r_scale : (r_scale - SW'(1));
  assign w_k      = w_esc >>> ES;
  assign w_e      = w_esc[ES-1:0];
  assign w_sticky = (r_rem != '0);
  assign w_tail   = {w_e, w_frac};
  assign w_sat_hi = (w_esc > MAXSC);
  assign w_sat_lo = (w_esc < MINSC);

  // Regime pattern: k+1 ones then 0 for k >= 0, -k zeros then 1 for k < 0.
  always_comb begin
    w_mask = '0;
    w_len  = '0;
    if (w_k >= 0) begin
      w_mask = ~({VW{1'b1}} >> (w_k + SW'(1)));
      w_len  = w_k + SW'(2);
    end else begin
      w_mask = {1'b1, {(VW-1){1'b0}}} >> (-w_k);
      w_len  = SW'(1) - w_k;
    end
  end

  assign w_v        = ({w_tail, {(VW-N+1){1'b0}}} >> w_len) | w_mask;
  assign w_body     = w_v[VW-1 -: N-1];
  assign w_guard    = w_v[VW-N];
  assign w_rest     = (|w_v[VW-N-1:0]) | w_sticky;
  assign w_round    = w_guard & (w_rest | w_body[0]);
  assign w_sum      = {1'b0, w_body} + N'(w_round);
  assign w_clamp_hi = w_sum[N-1];
  assign w_clamp_lo = (w_sum == '0);

  // Saturate out of range scales; rounding never produces 0 or NaR.
  always_comb begin
    w_mag = w_sum;
    if (w_sat_hi || w_clamp_hi) w_mag = MAXPOS;
    else if (w_sat_lo || w_clamp_lo) w_mag = MINPOS;
  end

  assign w_res = r_sign ? (~w_mag + 1'b1) : w_mag;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic; specials skip DIVIDE and pass through ENCODE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid && r_in_ready) w_next = S_DECODE;
      S_DECODE: w_next = w_special ? S_ENCODE : S_DIVIDE;
      S_DIVIDE: if (r_cnt == CW'(QW - 1)) w_next = S_ENCODE;
      S_ENCODE: w_next = S_DONE;
      S_DONE:   if (out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Registered handshake outputs follow the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == S_IDLE);
      r_out_valid <= (w_next == S_DONE);
    end
  end

  // Datapath: latch operands, decode, iterate the divider, encode result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_q       <= '0;
      r_sign    <= 1'b0;
      r_special <= 1'b0;
      r_scale   <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
`ifdef POSIT_DIV_FLAGS_EN
      r_flags   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a <= a;
            r_b <= b;
          end
        end
        S_DECODE: begin
          r_sign    <= r_a[N-1] ^ r_b[N-1];
          r_special <= w_special;
          r_scale   <= w_sa - w_sb;
          r_rem     <= {1'b0, 1'b1, w_da[FRAC_W-1:0]};
          r_div     <= {1'b1, w_db[FRAC_W-1:0]};
          r_quo     <= '0;
          r_cnt     <= '0;
          if (w_a_nar || w_b_nar || w_b_zero) r_q <= NAR;
          else if (w_a_zero)                  r_q <= '0;
`ifdef POSIT_DIV_FLAGS_EN
          if (w_special) r_flags <= {w_a_nar | w_b_nar | w_b_zero, 3'b000};
`endif
        end
        S_DIVIDE: begin
          r_rem <= {w_rem_sel[QW-3:0], 1'b0};
          r_quo <= {r_quo[QW-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
        end
        S_ENCODE: begin
          if (!r_special) begin
            r_q <= w_res;
`ifdef POSIT_DIV_FLAGS_EN
            r_flags <= {1'b0,
                        w_sat_hi | (!w_sat_lo && w_clamp_hi),
                        w_sat_lo | (!w_sat_hi && !w_clamp_hi && w_clamp_lo),
                        w_guard | w_rest | w_sat_hi | w_sat_lo | w_clamp_hi | w_clamp_lo};
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign q         = r_q;
`ifdef POSIT_DIV_FLAGS_EN
  assign flags     = r_flags;
`endif

endmodule

// File: tb/tb_posit_divider.sv
// Directed bench for posit_divider: reset values, arithmetic vectors with
// hand-computed quotients, specials, saturation, back-pressure and abort.
module tb_posit_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
`ifdef POSIT_DIV_FLAGS_EN
  logic [3:0]  flags;
`endif

  int n_checks = 0;
  int n_errors = 0;

  posit_divider #(.N(32), .ES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
`ifdef POSIT_DIV_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start one operation and wait (bounded) for its result; returns edges from
  // the accept edge to the first edge after which out_valid is seen high.
  task automatic start_and_wait(input logic [31:0] ia, input logic [31:0] ib, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    a = ia;
    b = ib;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Full directed operation: latency, quotient, flags, completion handshake.
  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] exp_q, input int exp_lat, input logic [3:0] exp_fl);
    int lat;
    start_and_wait(ia, ib, lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " q"}, q, exp_q);
`ifdef POSIT_DIV_FLAGS_EN
    check({tag, " flags"}, 32'(flags), 32'(exp_fl));
`else
    if (exp_fl === 4'bxxxx) $display("unexpected flag pattern for %s", tag);
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset q", q, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready after reset", 32'(in_ready), 32'd1);

    // Exact quotients.
    run_op("4/2",    32'h4400_0000, 32'h4200_0000, 32'h4200_0000, 30, 4'b0000);
    run_op("3/1.5",  32'h4300_0000, 32'h4100_0000, 32'h4200_0000, 30, 4'b0000);
    run_op("1/2",    32'h4000_0000, 32'h4200_0000, 32'h3E00_0000, 30, 4'b0000);
    run_op("1/-1",   32'h4000_0000, 32'hC000_0000, 32'hC000_0000, 30, 4'b0000);
    run_op("-1/-1",  32'hC000_0000, 32'hC000_0000, 32'h4000_0000, 30, 4'b0000);

    // Rounded quotients: 1/3 rounds up (guard=1, sticky=1).
    run_op("1/3",    32'h4000_0000, 32'h4300_0000, 32'h3CAA_AAAB, 30, 4'b0001);
    run_op("1/-3",   32'h4000_0000, 32'hBD00_0000, 32'hC355_5555, 30, 4'b0001);

    // Specials.
    run_op("x/0",    32'h4000_0000, 32'h0000_0000, 32'h8000_0000, 2, 4'b1000);
    run_op("NaR/x",  32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 2, 4'b1000);
    run_op("0/x",    32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 2, 4'b0000);

    // Saturation.
    run_op("max/min", 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 30, 4'b0101);
    run_op("min/max", 32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0001, 30, 4'b0011);

    // Back-pressure: result held while out_ready stays low; in_valid ignored.
    start_and_wait(32'h4400_0000, 32'h4200_0000, lat);
    check("hold latency", 32'(lat), 32'd30);
    a = 32'h4000_0000;
    b = 32'h0000_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold q", q, 32'h4200_0000);
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold release out_valid", 32'(out_valid), 32'd0);
    check("hold release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("no stray accept", 32'(in_ready), 32'd1);

    // Abort: reset pulse at cycle 15 of a divide discards the result.
    a = 32'h4400_0000;
    b = 32'h4200_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort in_ready after release", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort no result", 32'(seen), 32'd0);

    // Divider still usable after the abort.
    run_op("post-abort 1/2", 32'h4000_0000, 32'h4200_0000, 32'h3E00_0000, 30, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
